mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD, default `WORD from definitions.vh (64), data/address width.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive data grants tolerated while fetch waits (used only with MEM_ARB_FAIR_EN).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports if_req in 1, if_addr in WORD: fetch requester; req level-held until ack.
REQ-006 Ports if_ack out 1, if_rdata out WORD: fetch completion pulse and read data.
REQ-007 Ports d_req in 1, d_we in 1, d_addr in WORD, d_wdata in WORD: data requester; d_we=1 store, 0 load; all held until ack.
REQ-008 Ports d_ack out 1, d_rdata out WORD: data completion pulse and load data.
REQ-009 Ports mem_address out WORD, mem_write_data out WORD, mem_read out 1, mem_write out 1: command to the single-port memory.
REQ-010 Port mem_read_data in WORD: memory read data, valid the cycle after mem_read is asserted.

Function
REQ-011 FSM states IDLE, ACCESS, RESP; one access every 3 cycles maximum.
REQ-012 IDLE: if any req, latch owner, address, wdata, we into registers, go ACCESS; else stay IDLE.
REQ-013 Arbitration: data wins over fetch when both requests are asserted in the same IDLE cycle (fixed priority, subject to REQ-021).
REQ-014 ACCESS: mem_address/mem_write_data driven from latched registers; mem_read=~we, mem_write=we for exactly this one cycle; go RESP.
REQ-015 RESP: capture mem_read_data into the owner's rdata register on a read; assert the owner's ack for exactly this cycle; go IDLE.
REQ-016 Latency: req seen in IDLE at cycle N -> ack and valid rdata at cycle N+2.
REQ-017 On store completion, d_rdata holds its previous value; if_rdata/d_rdata change only on their own read completion.
REQ-018 Requester deasserts req in the cycle after ack; a req still high in the following IDLE is treated as a new request.
REQ-019 Request changes during ACCESS/RESP are ignored; latched values are used.
REQ-020 mem_read and mem_write are never both 1; both are 0 in IDLE and RESP.

Reset
REQ-021 reset forces IDLE; all outputs 0 (acks, mem_read, mem_write, mem_address, mem_write_data, if_rdata, d_rdata); starvation counter 0.
REQ-022 Reset during ACCESS or RESP aborts the access: no ack issued, outputs 0 the next cycle, pending requests re-arbitrated after reset deasserts.

Configuration
REQ-023 Macro MEM_ARB_FAIR_EN defined: counter increments per data grant while if_req is high, clears on any fetch grant or when if_req is low; at STARVE_LIMIT, the next IDLE grants fetch even if d_req is high.
REQ-024 Macro MEM_ARB_FAIR_EN undefined: pure fixed priority, no counter logic; fetch may starve indefinitely.

Structure
REQ-025 definitions.vh holds WORD, FSM state encodings (IDLE/ACCESS/RESP), and the owner encoding (OWN_IF, OWN_D).
REQ-026 Optional sub-module arb_starve_counter holds the REQ-023 counter and is instantiated only under MEM_ARB_FAIR_EN; the FSM remains in mem_arbiter.

Verification
REQ-027 Fetch-only: if_req=1, if_addr=0, mem word0=0xA -> mem_read at N+1, if_ack and if_rdata=0xA at N+2.
REQ-028 Store then load: d_we=1, d_addr=3, d_wdata=100 -> mem_write pulse, d_ack; then load addr 3 -> d_rdata=100, with d_rdata unchanged after the store ack.
REQ-029 Contention: if_req and d_req rise together -> data granted first (d_ack at N+2), fetch ack at N+5.
REQ-030 Fairness (MEM_ARB_FAIR_EN, STARVE_LIMIT=3): d_req and if_req held high -> 3 d_acks, then 1 if_ack, repeat; without the macro, if_ack never asserts.
REQ-031 Reset mid-ACCESS: assert reset in the ACCESS cycle -> next cycle all outputs 0, no ack; after release, the held req completes in 3 cycles.
REQ-032 Every scenario: mem_read & mem_write never both 1, and each ack is exactly 1 cycle wide.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the two-requester memory arbiter.
//   ARB_WORD : default data/address width
//   state_e  : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_e  : which requester owns the access in flight (OWN_IF, OWN_D)
// Optional fairness feature is enabled by defining MEM_ARB_FAIR_EN.
package mem_arbiter_pkg;

    localparam int unsigned ARB_WORD = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts consecutive data grants made while fetch waits and
// flags when fetch must be served next. Only built when MEM_ARB_FAIR_EN is defined.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   if_req_i    : fetch request level
//   grant_i     : an access is granted this cycle
//   grant_d_i   : the grant (if any) goes to the data requester
//   starve_o    : registered; fetch has waited STARVE_LIMIT data grants
`ifdef MEM_ARB_FAIR_EN
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic grant_i,
    input  logic grant_d_i,
    output logic starve_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count saturates at the limit; any fetch grant or idle fetch side clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i) begin
            cnt_d = '0;
        end else if (grant_i && !grant_d_i) begin
            cnt_d = '0;
        end else if (grant_i && grant_d_i && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            starve_o <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_o <= (cnt_d == CNT_W'(STARVE_LIMIT));
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch requester and a
// data requester. One access at most every three cycles (IDLE -> ACCESS -> RESP).
// Data has fixed priority; with MEM_ARB_FAIR_EN defined, fetch is forced through
// after STARVE_LIMIT consecutive data grants while it waits.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata   : fetch request, ack pulse, read data
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata : data load/store, ack pulse, load data
//   mem_address/mem_write_data/mem_read/mem_write : memory command (ACCESS cycle)
//   mem_read_data                       : memory data, valid the cycle after mem_read
module mem_arbiter #(
    parameter int unsigned WORD         = mem_arbiter_pkg::ARB_WORD,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [WORD-1:0] if_addr,
    output logic            if_ack,
    output logic [WORD-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [WORD-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_ack,
    output logic [WORD-1:0] d_rdata,
    output logic [WORD-1:0] mem_address,
    output logic [WORD-1:0] mem_write_data,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [WORD-1:0] mem_read_data
);

    import mem_arbiter_pkg::*;

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    state_e          state_q;
    owner_e          owner_q;
    logic            we_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic [WORD-1:0] if_rdata_q;
    logic [WORD-1:0] d_rdata_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            if_ack_q;
    logic            d_ack_q;

    logic            grant_c;
    logic            pick_d_c;
    logic            starve_c;

`ifdef MEM_ARB_FAIR_EN
    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .if_req_i (if_req),
        .grant_i  (grant_c),
        .grant_d_i(pick_d_c),
        .starve_o (starve_c)
    );
`else
    assign starve_c = 1'b0;
`endif

    // Data wins unless fetch has been starved and is still asking.
    assign grant_c  = (state_q == IDLE) && (if_req || d_req);
    assign pick_d_c = d_req && !(starve_c && if_req);

    // Arbiter FSM with registered command, ack and read-data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        owner_q     <= pick_d_c ? OWN_D : OWN_IF;
                        we_q        <= pick_d_c && d_we;
                        addr_q      <= pick_d_c ? d_addr : if_addr;
                        wdata_q     <= pick_d_c ? d_wdata : '0;
                        mem_read_q  <= !(pick_d_c && d_we);
                        mem_write_q <= pick_d_c && d_we;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if_ack_q    <= (owner_q == OWN_IF);
                    d_ack_q     <= (owner_q == OWN_D);
                    state_q     <= RESP;
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= mem_read_data;
                        end else begin
                            if_rdata_q <= mem_read_data;
                        end
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory data arrives during RESP, so the ack cycle shows it directly;
    // afterwards the held copy is presented until the owner's next load.
    assign if_rdata       = (if_ack_q && !we_q) ? mem_read_data : if_rdata_q;
    assign d_rdata        = (d_ack_q && !we_q) ? mem_read_data : d_rdata_q;
    assign if_ack         = if_ack_q;
    assign d_ack          = d_ack_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic and resets, checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int unsigned WORD         = 64;
    localparam int unsigned STARVE_LIMIT = 3;
    localparam int          MEMSZ        = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            if_req = 1'b0;
    logic [WORD-1:0] if_addr = '0;
    logic            if_ack;
    logic [WORD-1:0] if_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [WORD-1:0] d_addr = '0;
    logic [WORD-1:0] d_wdata = '0;
    logic            d_ack;
    logic [WORD-1:0] d_rdata;
    logic [WORD-1:0] mem_address;
    logic [WORD-1:0] mem_write_data;
    logic            mem_read;
    logic            mem_write;
    logic [WORD-1:0] mem_read_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mem_arbiter #(
        .WORD(WORD),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .if_rdata      (if_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_ack         (d_ack),
        .d_rdata       (d_rdata),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_word(input string name, input logic [WORD-1:0] act,
                              input logic [WORD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory behind the arbiter: synchronous write, read data one cycle after mem_read.
    logic [WORD-1:0] tmem [MEMSZ];
    initial begin
        for (int i = 0; i < MEMSZ; i++) tmem[i] = WORD'(i * 17 + 10);
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            if (mem_write) tmem[mem_address[3:0]] <= mem_write_data;
            if (mem_read) mem_read_data <= tmem[mem_address[3:0]];
        end
    end

    // Transaction-level model: a grant at cycle g means command at g+1, ack at g+2,
    // next arbitration at g+3. Reset cancels the transaction and clears outputs.
    logic [WORD-1:0] ref_mem [MEMSZ];
    int              tx_cyc = -100;
    int              next_free = 0;
    bit              tx_own_d = 1'b0;
    bit              tx_we = 1'b0;
    logic [WORD-1:0] tx_addr = '0;
    logic [WORD-1:0] tx_wdata = '0;
    logic [WORD-1:0] tx_rdata = '0;
    logic [WORD-1:0] h_if = '0;
    logic [WORD-1:0] h_d = '0;
    bit              known = 1'b0;
    bit              just_reset = 1'b0;
    int              starve_cnt = 0;

    initial begin
        bit cmd;
        bit ack;
        bit gd;
        bit granted;
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = WORD'(i * 17 + 10);
        forever begin
            @(negedge clk);
            cmd = (cyc == tx_cyc + 1);
            ack = (cyc == tx_cyc + 2);
            if (ack && !tx_we) begin
                if (tx_own_d) h_d = tx_rdata;
                else h_if = tx_rdata;
            end
            if (known) begin
                check_bit("m_mem_read", mem_read, cmd && !tx_we);
                check_bit("m_mem_write", mem_write, cmd && tx_we);
                check_bit("m_if_ack", if_ack, ack && !tx_own_d);
                check_bit("m_d_ack", d_ack, ack && tx_own_d);
                check_bit("m_rw_excl", mem_read && mem_write, 1'b0);
                check_word("m_if_rdata", if_rdata, h_if);
                check_word("m_d_rdata", d_rdata, h_d);
                if (cmd) begin
                    check_word("m_mem_address", mem_address, tx_addr);
                    if (tx_we) check_word("m_mem_wdata", mem_write_data, tx_wdata);
                end
                if (just_reset) begin
                    check_word("m_rst_address", mem_address, '0);
                    check_word("m_rst_wdata", mem_write_data, '0);
                end
            end
            just_reset = 1'b0;
            granted = 1'b0;
            gd = 1'b0;
            if (reset) begin
                known = 1'b1;
                just_reset = 1'b1;
                tx_cyc = -100;
                h_if = '0;
                h_d = '0;
                next_free = cyc + 1;
                starve_cnt = 0;
            end else if (known && cyc >= next_free && (if_req || d_req)) begin
                granted = 1'b1;
                gd = d_req;
`ifdef MEM_ARB_FAIR_EN
                if (if_req && starve_cnt >= STARVE_LIMIT) gd = 1'b0;
`endif
                tx_cyc = cyc;
                next_free = cyc + 3;
                tx_own_d = gd;
                tx_we = gd && d_we;
                tx_addr = gd ? d_addr : if_addr;
                tx_wdata = tx_we ? d_wdata : '0;
                if (tx_we) ref_mem[tx_addr[3:0]] = tx_wdata;
                else tx_rdata = ref_mem[tx_addr[3:0]];
            end
`ifdef MEM_ARB_FAIR_EN
            if (!reset && known) begin
                if (!if_req) starve_cnt = 0;
                else if (granted && !gd) starve_cnt = 0;
                else if (granted && gd && starve_cnt < STARVE_LIMIT) starve_cnt++;
            end
`endif
        end
    end

    // Directed scenarios, then random traffic.
    initial begin
        int  n_if;
        int  n_d;
        bit  a_if;
        bit  a_d;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_bit("rst_if_ack", if_ack, 1'b0);
        check_bit("rst_d_ack", d_ack, 1'b0);
        check_bit("rst_mem_read", mem_read, 1'b0);
        check_bit("rst_mem_write", mem_write, 1'b0);
        check_word("rst_if_rdata", if_rdata, '0);
        check_word("rst_d_rdata", d_rdata, '0);

        // Fetch only, word 0 holds 0xA.
        @(posedge clk); #1 if_req = 1'b1; if_addr = '0;
        @(negedge clk); check_bit("f_rd_n", mem_read, 1'b0);
        @(negedge clk); check_bit("f_rd_n1", mem_read, 1'b1);
        @(negedge clk); check_bit("f_ack_n2", if_ack, 1'b1);
        check_word("f_rdata_n2", if_rdata, WORD'(10));
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk); check_bit("f_ack_width", if_ack, 1'b0);
        check_word("f_rdata_hold", if_rdata, WORD'(10));

        // Store 100 to address 3, then load it back.
        @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = WORD'(3); d_wdata = WORD'(100);
        @(negedge clk);
        @(negedge clk); check_bit("s_mem_write", mem_write, 1'b1);
        check_word("s_wdata", mem_write_data, WORD'(100));
        @(negedge clk); check_bit("s_ack", d_ack, 1'b1);
        check_word("s_rdata_kept", d_rdata, '0);
        @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1 d_req = 1'b1;
        @(negedge clk);
        @(negedge clk); check_bit("l_mem_read", mem_read, 1'b1);
        @(negedge clk); check_bit("l_ack", d_ack, 1'b1);
        check_word("l_rdata", d_rdata, WORD'(100));
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk); check_word("l_rdata_hold", d_rdata, WORD'(100));

        // Contention: both rise together, data first.
        @(posedge clk); #1 if_req = 1'b1; if_addr = WORD'(5); d_req = 1'b1; d_addr = WORD'(7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); check_bit("c_d_ack", d_ack, 1'b1);
        check_bit("c_if_wait", if_ack, 1'b0);
        check_word("c_d_rdata", d_rdata, WORD'(129));
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        @(negedge clk); check_word("c_if_addr", mem_address, WORD'(5));
        @(negedge clk); check_bit("c_if_ack_n5", if_ack, 1'b1);
        check_word("c_if_rdata", if_rdata, WORD'(95));
        @(posedge clk); #1 if_req = 1'b0;

        // Reset in the ACCESS cycle aborts; held request completes afterwards.
        @(posedge clk); #1 if_req = 1'b1; if_addr = WORD'(2);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); check_bit("r_in_access", mem_read, 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); check_bit("r_rd_zero", mem_read, 1'b0);
        check_bit("r_no_ack", if_ack, 1'b0);
        check_word("r_addr_zero", mem_address, '0);
        check_word("r_if_rdata_zero", if_rdata, '0);
        check_word("r_d_rdata_zero", d_rdata, '0);
        @(negedge clk); check_bit("r_retry_rd", mem_read, 1'b1);
        @(negedge clk); check_bit("r_retry_ack", if_ack, 1'b1);
        check_word("r_retry_rdata", if_rdata, WORD'(44));
        @(posedge clk); #1 if_req = 1'b0;

        // Both requesters held for eight access slots.
        @(posedge clk); #1 if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = WORD'(1); d_addr = WORD'(4);
        n_if = 0;
        n_d = 0;
        repeat (24) begin
            @(negedge clk);
            n_if += int'(if_ack);
            n_d += int'(d_ack);
        end
        @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        check_word("fair_if_acks", WORD'(n_if), WORD'(2));
        check_word("fair_d_acks", WORD'(n_d), WORD'(6));
`else
        check_word("prio_if_acks", WORD'(n_if), WORD'(0));
        check_word("prio_d_acks", WORD'(n_d), WORD'(8));
`endif

        // Random traffic with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            a_if = if_ack;
            a_d = d_ack;
            @(posedge clk); #1;
            if (reset) reset = ($urandom % 2) == 0;
            else reset = ($urandom % 97) == 0;
            if (a_if) begin
                if_req = 1'b0;
            end else if (!if_req && ($urandom % 3) == 0) begin
                if_req = 1'b1;
                if_addr = {$urandom, $urandom};
            end
            if (a_d) begin
                d_req = 1'b0;
            end else if (!d_req && ($urandom % 3) == 0) begin
                d_req = 1'b1;
                d_we = $urandom % 2;
                d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
            end
        end
        reset = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
